// File: rtl/mips_main_control.sv
// ---------------------------------------------------------------------------
// mips_main_control
//
// Main control decoder for the ID stage of the 5-stage MIPS pipeline.
// The 6-bit opcode is decoded into:
//   - jump and branch, which act directly in ID,
//   - an 8-bit control bundle for the EX/MEM/WB stages (idexControl),
//   - a registered ID/EX copy of that bundle (idex_ctrl_q).
// The hazard unit can hold the registered copy (stall) or replace it
// with a bubble (flush).
//
// Parameters:
//   OPW   opcode width (only 6 is meaningful)
//   CTLW  width of the ID/EX control bundle (8)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   opcode       in   instruction bits [31:26] from IF/ID
//   stall        in   hold idex_ctrl_q
//   flush        in   load a bubble (all zeros) into idex_ctrl_q
//   jump         out  combinational, 1 for j
//   branch       out  combinational, {is_branch, is_bne}
//   idexControl  out  combinational decode of opcode
//   idex_ctrl_q  out  registered ID/EX copy of idexControl
//
// Optional build macro CTRL_ILLEGAL_DET_EN adds:
//   illegal_op   out  combinational, 1 for any opcode not in the table
//   illegal_seen out  sticky flag, set when illegal_op is seen while the
//                     pipeline is not stalled; cleared only by reset_n
//
// idexControl bit map:
//   [7] RegDst  [6] ALUSrc  [5] MemtoReg  [4] RegWrite
//   [3] MemRead [2] MemWrite [1:0] ALUOp (00 add, 01 sub, 10 funct, 11 and)
//
// Downstream branch resolution: taken = branch[1] & (branch[0] ^ eq).
// ---------------------------------------------------------------------------
module mips_main_control #(
   parameter int OPW  = 6,
   parameter int CTLW = 8
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [OPW-1:0]  opcode,
   input  logic            stall,
   input  logic            flush,
   output logic            jump,
   output logic [1:0]      branch,
   output logic [CTLW-1:0] idexControl,
`ifdef CTRL_ILLEGAL_DET_EN
   output logic            illegal_op,
   output logic            illegal_seen,
`endif
   output logic [CTLW-1:0] idex_ctrl_q
);

   // Opcodes understood by this decoder.
   localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPW-1:0] OP_LW    = 6'b100011;
   localparam logic [OPW-1:0] OP_SW    = 6'b101011;
   localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPW-1:0] OP_J     = 6'b000010;

   // ALUOp encodings seen by the ALU control unit.
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_AND   = 2'b11;

   // Individual control fields, assembled into the bundle below.
   logic       reg_dst;
   logic       alu_src;
   logic       mem_to_reg;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic [1:0] alu_op;
   logic       is_branch;
   logic       is_bne;
   logic       is_jump;
`ifdef CTRL_ILLEGAL_DET_EN
   logic       is_illegal;
`endif

   // Opcode decode. Every field defaults to zero so that any opcode not
   // listed falls through as a nop with no architectural side effects.
   always_comb begin
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = ALU_ADD;
      is_branch  = 1'b0;
      is_bne     = 1'b0;
      is_jump    = 1'b0;
`ifdef CTRL_ILLEGAL_DET_EN
      is_illegal = 1'b0;
`endif
      case (opcode)
         OP_RTYPE: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         OP_LW: begin
            alu_src    = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            mem_read   = 1'b1;
            alu_op     = ALU_ADD;
         end
         OP_SW: begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
            alu_op    = ALU_ADD;
         end
         OP_ADDI: begin
            alu_src   = 1'b1;
            reg_write = 1'b1;
            alu_op    = ALU_ADD;
         end
         OP_ANDI: begin
            alu_src   = 1'b1;
            reg_write = 1'b1;
            alu_op    = ALU_AND;
         end
         OP_BEQ: begin
            alu_op    = ALU_SUB;
            is_branch = 1'b1;
         end
         OP_BNE: begin
            alu_op    = ALU_SUB;
            is_branch = 1'b1;
            is_bne    = 1'b1;
         end
         OP_J: begin
            is_jump = 1'b1;
         end
         default: begin
`ifdef CTRL_ILLEGAL_DET_EN
            is_illegal = 1'b1;
`endif
         end
      endcase
   end

   // Pack the bundle in the bit order the EX/MEM/WB stages expect.
   always_comb begin
      idexControl = {reg_dst, alu_src, mem_to_reg, reg_write,
                     mem_read, mem_write, alu_op};
      branch      = {is_branch, is_bne};
      jump        = is_jump;
   end

   // ID/EX control register. Flush outranks stall so that a bubble can
   // always be inserted even while the hazard unit is holding the stage.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idex_ctrl_q <= '0;
      end else if (flush) begin
         idex_ctrl_q <= '0;
      end else if (!stall) begin
         idex_ctrl_q <= idexControl;
      end
   end

`ifdef CTRL_ILLEGAL_DET_EN
   always_comb begin
      illegal_op = is_illegal;
   end

   // Sticky illegal-opcode flag. A stalled opcode is not yet committed to
   // the pipeline, so it is only recorded once the stage is free to advance.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         illegal_seen <= 1'b0;
      end else if (is_illegal && !stall) begin
         illegal_seen <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_main_control.sv
// ---------------------------------------------------------------------------
// tb_mips_main_control
//
// Self-checking bench for mips_main_control. Expected values come from a
// table of instruction encodings and a small register model kept here.
// Directed steps cover the decode table, an undefined opcode, stall/flush
// priority and asynchronous reset; a randomized section then mixes legal
// and arbitrary opcodes with random stall/flush.
// Define CTRL_ILLEGAL_DET_EN when compiling to also check the illegal
// opcode outputs.
// ---------------------------------------------------------------------------
module tb_mips_main_control;

   logic       clock;
   logic       reset_n;
   logic [5:0] opcode;
   logic       stall;
   logic       flush;
   logic       jump;
   logic [1:0] branch;
   logic [7:0] idexControl;
   logic [7:0] idex_ctrl_q;
`ifdef CTRL_ILLEGAL_DET_EN
   logic       illegal_op;
   logic       illegal_seen;
`endif

   int checks = 0;
   int errors = 0;

   // Reference decode table: one entry per supported instruction.
   typedef struct {
      logic [5:0] op;
      logic [7:0] ctl;
      logic [1:0] br;
      logic       jmp;
   } dec_t;

   dec_t decTable[$];

   // Register model state.
   logic [7:0] expQ    = 8'h00;
   logic       expSeen = 1'b0;

   mips_main_control #(.OPW(6), .CTLW(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .opcode      (opcode),
      .stall       (stall),
      .flush       (flush),
      .jump        (jump),
      .branch      (branch),
      .idexControl (idexControl),
`ifdef CTRL_ILLEGAL_DET_EN
      .illegal_op  (illegal_op),
      .illegal_seen(illegal_seen),
`endif
      .idex_ctrl_q (idex_ctrl_q)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Look an opcode up in the reference table; anything absent is a nop.
   function automatic void refDecode(input logic [5:0] op,
                                     output logic [7:0] ctl,
                                     output logic [1:0] br,
                                     output logic jmp,
                                     output logic ill);
      ctl = 8'h00;
      br  = 2'b00;
      jmp = 1'b0;
      ill = 1'b1;
      foreach (decTable[i]) begin
         if (decTable[i].op == op) begin
            ctl = decTable[i].ctl;
            br  = decTable[i].br;
            jmp = decTable[i].jmp;
            ill = 1'b0;
         end
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] obs,
                              input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   // Drive one opcode with stall/flush, check the combinational decode,
   // then advance one rising edge and check the registered state.
   task automatic applyStimulus(input logic [5:0] op, input logic st,
                                input logic fl);
      logic [7:0] eCtl;
      logic [1:0] eBr;
      logic       eJmp;
      logic       eIll;
      opcode = op;
      stall  = st;
      flush  = fl;
      refDecode(op, eCtl, eBr, eJmp, eIll);
      #1;
      checkOutput($sformatf("idexControl op=%06b", op), idexControl, eCtl);
      checkOutput($sformatf("branch op=%06b", op), {6'b0, branch}, {6'b0, eBr});
      checkOutput($sformatf("jump op=%06b", op), {7'b0, jump}, {7'b0, eJmp});
`ifdef CTRL_ILLEGAL_DET_EN
      checkOutput($sformatf("illegal_op op=%06b", op), {7'b0, illegal_op},
                  {7'b0, eIll});
`endif
      @(posedge clock);
      if (fl)
         expQ = 8'h00;
      else if (!st)
         expQ = eCtl;
      if (eIll && !st)
         expSeen = 1'b1;
      #1;
      checkOutput($sformatf("idex_ctrl_q op=%06b st=%0b fl=%0b", op, st, fl),
                  idex_ctrl_q, expQ);
`ifdef CTRL_ILLEGAL_DET_EN
      checkOutput("illegal_seen", {7'b0, illegal_seen}, {7'b0, expSeen});
`endif
   endtask

   // Resolve a branch the way the downstream logic does, from the DUT's
   // branch output, and compare with the expected outcome.
   task automatic checkTaken(input logic [5:0] op, input logic eq,
                             input logic expTaken);
      logic taken;
      opcode = op;
      #1;
      taken = branch[1] & (branch[0] ^ eq);
      checkOutput($sformatf("taken op=%06b eq=%0b", op, eq), {7'b0, taken},
                  {7'b0, expTaken});
   endtask

   initial begin
      logic [5:0] rop;
      logic       rst;
      logic       rfl;

      decTable.push_back('{op: 6'b000000, ctl: 8'h92, br: 2'b00, jmp: 1'b0});
      decTable.push_back('{op: 6'b100011, ctl: 8'h78, br: 2'b00, jmp: 1'b0});
      decTable.push_back('{op: 6'b101011, ctl: 8'h44, br: 2'b00, jmp: 1'b0});
      decTable.push_back('{op: 6'b001000, ctl: 8'h50, br: 2'b00, jmp: 1'b0});
      decTable.push_back('{op: 6'b001100, ctl: 8'h53, br: 2'b00, jmp: 1'b0});
      decTable.push_back('{op: 6'b000100, ctl: 8'h01, br: 2'b10, jmp: 1'b0});
      decTable.push_back('{op: 6'b000101, ctl: 8'h01, br: 2'b11, jmp: 1'b0});
      decTable.push_back('{op: 6'b000010, ctl: 8'h00, br: 2'b00, jmp: 1'b1});

      // Reset asserted away from any clock edge.
      reset_n = 1'b1;
      opcode  = 6'b000000;
      stall   = 1'b0;
      flush   = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("reset idex_ctrl_q", idex_ctrl_q, 8'h00);
`ifdef CTRL_ILLEGAL_DET_EN
      checkOutput("reset illegal_seen", {7'b0, illegal_seen}, 8'h00);
`endif
      #1;
      reset_n = 1'b1;

      // Full decode table followed by an undefined opcode.
      foreach (decTable[i])
         applyStimulus(decTable[i].op, 1'b0, 1'b0);
      applyStimulus(6'b111111, 1'b0, 1'b0);

      // Load lw, then hold it across two stalled edges with a new opcode.
      applyStimulus(6'b100011, 1'b0, 1'b0);
      applyStimulus(6'b000000, 1'b1, 1'b0);
      applyStimulus(6'b000000, 1'b1, 1'b0);
      checkOutput("stall holds lw", idex_ctrl_q, 8'h78);

      // Flush wins over stall.
      applyStimulus(6'b000000, 1'b1, 1'b1);
      checkOutput("flush beats stall", idex_ctrl_q, 8'h00);

      // Asynchronous reset mid-cycle; decode keeps tracking opcode while
      // reset is held, including branch resolution.
      applyStimulus(6'b100011, 1'b0, 1'b0);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset idex_ctrl_q", idex_ctrl_q, 8'h00);
      opcode = 6'b101011;
      #1;
      checkOutput("decode during reset", idexControl, 8'h44);
      checkTaken(6'b000100, 1'b1, 1'b1);
      checkTaken(6'b000101, 1'b0, 1'b1);
      checkTaken(6'b000100, 1'b0, 1'b0);
      checkTaken(6'b000101, 1'b1, 1'b0);
      reset_n = 1'b1;
      expQ    = 8'h00;
      expSeen = 1'b0;

      // Randomized mix of table opcodes and arbitrary encodings.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 2) != 0)
            rop = decTable[$urandom_range(0, decTable.size() - 1)].op;
         else
            rop = 6'($urandom_range(0, 63));
         rst = ($urandom_range(0, 3) == 0);
         rfl = ($urandom_range(0, 7) == 0);
         applyStimulus(rop, rst, rfl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_main_control.md
Name: mips_main_control

Overview:
- Main control decoder for the 5-stage MIPS pipeline, located in the ID stage.
- Decodes the 6-bit instruction opcode into jump and branch controls, which act in ID.
- Also produces an 8-bit control bundle for the ID/EX stage, both combinationally and as a registered ID/EX copy.
- The registered copy supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- OPW, 6, opcode width; only 6 is supported.
- CTLW, 8, width of the ID/EX control bundle.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction bits [31:26] from IF/ID.
- stall  in  1  hold the registered bundle.
- flush  in  1  load a bubble (all zeros) into the registered bundle.
- jump  out  1  combinational; 1 for j.
- branch  out  2  combinational; {is_branch, is_bne}.
- idexControl  out  8  combinational decode of opcode.
- idex_ctrl_q  out  8  registered ID/EX copy of idexControl.

Behaviour:
- idexControl bit map:
  - [7] RegDst, [6] ALUSrc, [5] MemtoReg, [4] RegWrite, [3] MemRead, [2] MemWrite.
  - [1:0] ALUOp: 00 add, 01 sub, 10 R-type funct, 11 and.
- Decode table (opcode -> idexControl / branch / jump):
  - 000000 R-type -> 0x92 / 00 / 0
  - 100011 lw -> 0x78 / 00 / 0
  - 101011 sw -> 0x44 / 00 / 0
  - 001000 addi -> 0x50 / 00 / 0
  - 001100 andi -> 0x53 / 00 / 0
  - 000100 beq -> 0x01 / 10 / 0
  - 000101 bne -> 0x01 / 11 / 0
  - 000010 j -> 0x00 / 00 / 1
  - any other opcode -> 0x00 / 00 / 0 (acts as a nop, no side effects).
- jump, branch and idexControl are purely combinational: no latency, no dependence on clock or reset.
- Branch-taken logic downstream: taken = branch[1] & (branch[0] ^ eq).
- idex_ctrl_q register:
  - reset_n low: clears to 0x00 asynchronously, regardless of clock.
  - Otherwise updates on the rising clock edge, in priority order:
    - flush=1 -> 0x00.
    - else stall=1 -> hold the current value.
    - else -> load idexControl.
  - flush takes priority over stall when both are 1.
  - Latency from opcode to idex_ctrl_q is exactly one clock.
- Reset release is synchronised by the first active edge; no other state exists.

Optional Feature:
- Macro: CTRL_ILLEGAL_DET_EN.
- When defined, the block adds two outputs:
  - illegal_op (1 bit): combinational; 1 for any opcode not listed in the decode table.
  - illegal_seen (1 bit): sticky register; set on any clock edge where illegal_op=1 and stall=0; cleared only by reset_n low.
- When undefined:
  - Neither port exists.
  - Undefined opcodes still decode to all zeros.

Test Plan:
- Opcode sequence 000000, 100011, 101011, 001000, 001100, 000100, 000101, 000010, applied 10 ns apart -> idexControl 0x92, 0x78, 0x44, 0x50, 0x53, 0x01, 0x01, 0x00; branch 00, 00, 00, 00, 00, 10, 11, 00; jump 1 only for 000010.
- Opcode 111111 -> idexControl 0x00, branch 00, jump 0; with CTRL_ILLEGAL_DET_EN, illegal_op=1 and illegal_seen=1 after the next edge.
- opcode=100011, stall=0, flush=0, one clock edge -> idex_ctrl_q=0x78; change opcode to 000000 with stall=1 -> idex_ctrl_q stays 0x78 across edges.
- idex_ctrl_q=0x78, stall=1 and flush=1 together -> 0x00 after the edge.
- reset_n pulled low mid-cycle with no clock edge -> idex_ctrl_q=0x00 immediately; combinational outputs still track opcode during reset.
- Branch check with eq: branch=10, eq=1 -> taken; branch=11, eq=0 -> taken; branch=10, eq=0 -> not taken; branch=11, eq=1 -> not taken.
